array_wta_min: RTL

- Winner-take-all stage directly downstream of the per-element cost saturation stage in the SGM disparity path.
- Takes one array of ArrL saturated matching costs per valid cycle and outputs the disparity index of the minimum cost, plus the minimum cost itself.
- Uses a pipelined binary comparison tree with a streaming valid/start-of-line sideband.
- Also provides a per-line column counter, so the downstream disparity writer needs no address logic.

---
 rtl/array_wta_min.sv | 120 ++++++++++++
 1 files changed

// File: rtl/array_wta_min.sv
// Winner-take-all over one array of saturated matching costs per cycle: a pipelined
// binary min tree returns the lowest index among the minima, its cost, and a per-line column.
module array_wta_min #(
  parameter int dataIn_depth = 4,
  parameter int ArrL         = 32,
  parameter int IdxW         = 5,
  parameter int ColW         = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [dataIn_depth*ArrL-1:0]   DIn,
  input  logic                           DIn_valid,
  input  logic                           DIn_sol,
  output logic [IdxW-1:0]                DOut_idx,
  output logic [dataIn_depth-1:0]        DOut_cost,
  output logic                           DOut_nomatch,
  output logic [ColW-1:0]                DOut_col,
  output logic                           DOut_sol,
  output logic                           DOut_valid
);

  // Streaming handshake: no backpressure. DIn/DIn_sol are consumed on every cycle
  // with DIn_valid=1; DOut_* are meaningful only on cycles with DOut_valid=1, which
  // follow the matching input by exactly IdxW cycles, gaps preserved.

  // v_st[j]/s_st[j] is the valid/sol sideband arriving at tree level j+1.
  logic [IdxW-1:0] v_q, s_q;
  logic [IdxW-1:0] v_st, s_st;

  always_comb begin
    v_st    = '0;
    s_st    = '0;
    v_st[0] = DIn_valid;
    s_st[0] = DIn_sol & DIn_valid;
    for (int j = 1; j < IdxW; j++) begin
      v_st[j] = v_q[j-1];
      s_st[j] = s_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      s_q <= '0;
    end else begin
      v_q <= v_st;
      s_q <= s_st;
    end
  end

  // The left operand always carries the lower indices, so it keeps ties.
  for (genvar k = 1; k <= IdxW; k++) begin : lvl
    for (genvar i = 0; i < (ArrL >> k); i++) begin : node
      logic [dataIn_depth-1:0] ca, cb, w_c, c_q;
      logic [IdxW-1:0]         xa, xb, w_x, x_q;

      if (k == 1) begin : leaf
        assign ca = DIn[dataIn_depth*(2*i)   +: dataIn_depth];
        assign cb = DIn[dataIn_depth*(2*i+1) +: dataIn_depth];
        assign xa = IdxW'(2*i);
        assign xb = IdxW'(2*i+1);
      end else begin : inner
        assign ca = lvl[k-1].node[2*i].c_q;
        assign cb = lvl[k-1].node[2*i+1].c_q;
        assign xa = lvl[k-1].node[2*i].x_q;
        assign xb = lvl[k-1].node[2*i+1].x_q;
      end

      always_comb begin
        w_c = ca;
        w_x = xa;
        if (cb < ca) begin
          w_c = cb;
          w_x = xb;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          c_q <= '0;
          x_q <= '0;
        end else begin
          c_q <= w_c;
          x_q <= w_x;
        end
      end
    end
  end

  logic            nm_q;
  logic [ColW-1:0] col_q, next_col;

  // next_col is the column the next non-sol output will take.
  always_ff @(posedge clk) begin
    if (rst) begin
      nm_q     <= 1'b0;
      col_q    <= '0;
      next_col <= '0;
    end else begin
      nm_q <= &lvl[IdxW].node[0].w_c;
      if (v_st[IdxW-1]) begin
        if (s_st[IdxW-1]) begin
          col_q    <= '0;
          next_col <= ColW'(1);
        end else begin
          col_q    <= next_col;
          next_col <= next_col + ColW'(1);
        end
      end
    end
  end

  assign DOut_idx     = lvl[IdxW].node[0].x_q;
  assign DOut_cost    = lvl[IdxW].node[0].c_q;
  assign DOut_nomatch = nm_q;
  assign DOut_col     = col_q;
  assign DOut_sol     = s_q[IdxW-1];
  assign DOut_valid   = v_q[IdxW-1];

endmodule
